// File: rtl/collatz_sequence_monitor_pkg.sv
// Shared constants for the Collatz sequence monitor: state encoding,
// terminal term value and default counter widths.
package collatz_sequence_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A Collatz run ends when the datapath presents this term.
    localparam int COLLATZ_TERMINAL = 1;

    localparam int DEF_DATAWIDTH_BUS   = 8;
    localparam int DEF_DATAWIDTH_STEPS = 8;
    localparam int DEF_DATAWIDTH_STALL = 5;
    localparam int DEF_STALL_LIMIT     = 16;

endpackage

// File: rtl/collatz_sequence_monitor_next_term.sv
// Combinational Collatz successor of a term, wrapping at W bits like the
// datapath does. Only used when COLLATZ_MONITOR_CHECK_EN is defined.
module collatz_next_term #(
    parameter int W = 8
) (
    input  logic [W-1:0] term_i,
    output logic [W-1:0] next_o
);

    logic [W+1:0] wide;

    always_comb begin
        wide = '0;
        if (term_i[0]) begin
            // 3t + 1 built as 2t + t + 1; two guard bits hold the carry-out.
            wide = {1'b0, term_i, 1'b0} + {2'b00, term_i} + (W+2)'(1);
        end else begin
            wide = {3'b000, term_i[W-1:1]};
        end
        next_o = W'(wide);
    end

endmodule

// File: rtl/collatz_sequence_monitor.sv
// Observer of the Collatz datapath output bus: counts steps, tracks the peak
// term and detects termination by reaching 1 or by stall.
// Optional sequence checker enabled by defining COLLATZ_MONITOR_CHECK_EN.
module collatz_sequence_monitor
    import collatz_sequence_monitor_pkg::*;
#(
    parameter int DATAWIDTH_BUS   = DEF_DATAWIDTH_BUS,
    parameter int DATAWIDTH_STEPS = DEF_DATAWIDTH_STEPS,
    parameter int DATAWIDTH_STALL = DEF_DATAWIDTH_STALL,
    parameter int STALL_LIMIT     = DEF_STALL_LIMIT
) (
    input  logic                       COLLATZ_MONITOR_CLOCK_50,
    input  logic                       COLLATZ_MONITOR_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]   COLLATZ_MONITOR_data_InBUS,
    input  logic                       COLLATZ_MONITOR_start_InHigh,
    output logic [DATAWIDTH_STEPS-1:0] COLLATZ_MONITOR_steps_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]   COLLATZ_MONITOR_peak_OutBUS,
    output logic                       COLLATZ_MONITOR_busy_OutHigh,
    output logic                       COLLATZ_MONITOR_done_OutHigh,
    output logic                       COLLATZ_MONITOR_stall_OutHigh,
    output logic                       COLLATZ_MONITOR_stepsat_OutHigh,
    output logic                       COLLATZ_MONITOR_checkerror_OutHigh
);

    localparam logic [DATAWIDTH_BUS-1:0]   TERM_VAL  = DATAWIDTH_BUS'(COLLATZ_TERMINAL);
    localparam logic [DATAWIDTH_STALL-1:0] STALL_LIM = DATAWIDTH_STALL'(STALL_LIMIT);

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic [DATAWIDTH_BUS-1:0]   data;

    assign clk   = COLLATZ_MONITOR_CLOCK_50;
    assign rst   = COLLATZ_MONITOR_RESET_InHigh;
    assign start = COLLATZ_MONITOR_start_InHigh;
    assign data  = COLLATZ_MONITOR_data_InBUS;

    state_e                     state_q;
    logic [DATAWIDTH_STEPS-1:0] steps_q;
    logic [DATAWIDTH_STEPS-1:0] steps_d;
    logic [DATAWIDTH_BUS-1:0]   peak_q;
    logic [DATAWIDTH_BUS-1:0]   peak_d;
    logic [DATAWIDTH_BUS-1:0]   last_q;
    logic [DATAWIDTH_STALL-1:0] stall_cnt_q;
    logic [DATAWIDTH_STALL-1:0] stall_cnt_d;
    logic                       busy_q;
    logic                       done_q;
    logic                       stall_q;
    logic                       stepsat_q;

    logic                       new_term;
    logic                       is_terminal;
    logic                       steps_full;

    assign new_term    = (data != last_q);
    assign is_terminal = (data == TERM_VAL);
    assign steps_full  = &steps_q;
    assign steps_d     = steps_full ? steps_q : steps_q + 1'b1;
    assign peak_d      = (data > peak_q) ? data : peak_q;
    assign stall_cnt_d = stall_cnt_q + 1'b1;

    // start outranks RUN/DONE handling; the status flags are registered
    // alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            steps_q     <= '0;
            peak_q      <= '0;
            last_q      <= '0;
            stall_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
            stepsat_q   <= 1'b0;
        end else if (start) begin
            last_q      <= data;
            peak_q      <= data;
            steps_q     <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            stepsat_q   <= 1'b0;
            if (is_terminal) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (new_term) begin
                        last_q      <= data;
                        stall_cnt_q <= '0;
                        peak_q      <= peak_d;
                        steps_q     <= steps_d;
                        if (steps_full) begin
                            stepsat_q <= 1'b1;
                        end
                        if (is_terminal) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        stall_cnt_q <= stall_cnt_d;
                        if (stall_cnt_d == STALL_LIM) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            stall_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef COLLATZ_MONITOR_CHECK_EN
    logic [DATAWIDTH_BUS-1:0] expected_term;
    logic                     checkerror_q;

    collatz_next_term #(
        .W (DATAWIDTH_BUS)
    ) u_next_term (
        .term_i (last_q),
        .next_o (expected_term)
    );

    // Sticky until the next start; never influences state or counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            checkerror_q <= 1'b0;
        end else if (start) begin
            checkerror_q <= 1'b0;
        end else if ((state_q == ST_RUN) && new_term && (data != expected_term)) begin
            checkerror_q <= 1'b1;
        end
    end

    assign COLLATZ_MONITOR_checkerror_OutHigh = checkerror_q;
`else
    assign COLLATZ_MONITOR_checkerror_OutHigh = 1'b0;
`endif

    assign COLLATZ_MONITOR_steps_OutBUS    = steps_q;
    assign COLLATZ_MONITOR_peak_OutBUS     = peak_q;
    assign COLLATZ_MONITOR_busy_OutHigh    = busy_q;
    assign COLLATZ_MONITOR_done_OutHigh    = done_q;
    assign COLLATZ_MONITOR_stall_OutHigh   = stall_q;
    assign COLLATZ_MONITOR_stepsat_OutHigh = stepsat_q;

endmodule

// File: tb/tb_collatz_sequence_monitor.sv
// Self-checking bench for collatz_sequence_monitor: a default instance and a
// 3-bit step-counter instance share the same stimulus.
module tb_collatz_sequence_monitor;

`ifdef COLLATZ_MONITOR_CHECK_EN
    localparam bit CE_ON = 1'b1;
`else
    localparam bit CE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;

    logic [7:0] steps, peak;
    logic       busy, done, stall, stepsat, cerr;
    logic [2:0] steps_s;
    logic [7:0] peak_s;
    logic       busy_s, done_s, stall_s, stepsat_s, cerr_s;

    logic [20:0] obs;
    logic [15:0] obs_s;
    assign obs   = {busy, done, stall, stepsat, cerr, steps, peak};
    assign obs_s = {busy_s, done_s, stall_s, stepsat_s, cerr_s, steps_s, peak_s};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collatz_sequence_monitor dut (
        .COLLATZ_MONITOR_CLOCK_50           (clk),
        .COLLATZ_MONITOR_RESET_InHigh       (rst),
        .COLLATZ_MONITOR_data_InBUS         (data),
        .COLLATZ_MONITOR_start_InHigh       (start),
        .COLLATZ_MONITOR_steps_OutBUS       (steps),
        .COLLATZ_MONITOR_peak_OutBUS        (peak),
        .COLLATZ_MONITOR_busy_OutHigh       (busy),
        .COLLATZ_MONITOR_done_OutHigh       (done),
        .COLLATZ_MONITOR_stall_OutHigh      (stall),
        .COLLATZ_MONITOR_stepsat_OutHigh    (stepsat),
        .COLLATZ_MONITOR_checkerror_OutHigh (cerr)
    );

    collatz_sequence_monitor #(.DATAWIDTH_STEPS(3)) dut_s (
        .COLLATZ_MONITOR_CLOCK_50           (clk),
        .COLLATZ_MONITOR_RESET_InHigh       (rst),
        .COLLATZ_MONITOR_data_InBUS         (data),
        .COLLATZ_MONITOR_start_InHigh       (start),
        .COLLATZ_MONITOR_steps_OutBUS       (steps_s),
        .COLLATZ_MONITOR_peak_OutBUS        (peak_s),
        .COLLATZ_MONITOR_busy_OutHigh       (busy_s),
        .COLLATZ_MONITOR_done_OutHigh       (done_s),
        .COLLATZ_MONITOR_stall_OutHigh      (stall_s),
        .COLLATZ_MONITOR_stepsat_OutHigh    (stepsat_s),
        .COLLATZ_MONITOR_checkerror_OutHigh (cerr_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collatz successor with the datapath's 8-bit wrap.
    function automatic logic [7:0] next_term(input logic [7:0] t);
        int v;
        v = int'(t);
        if (v % 2 == 0) return 8'(v / 2);
        return 8'((3 * v + 1) % 256);
    endfunction

    // Stopping time and peak of a seed; ok=0 if 1 is not reached in 200 terms.
    function automatic void model_run(input logic [7:0] seed, output int n,
                                      output logic [7:0] pk, output bit ok);
        logic [7:0] t;
        t  = seed;
        n  = 0;
        pk = seed;
        ok = 1'b0;
        while (n < 200) begin
            if (t == 8'd1) begin
                ok = 1'b1;
                return;
            end
            t = next_term(t);
            n++;
            if (t > pk) pk = t;
        end
    endfunction

    // Presents seed with start, then each term for hold cycles; reports the
    // edge index (start edge = 0) where done first appears and the number of
    // cycles where busy/done disagreed with that moment.
    task automatic drive_run(input logic [7:0] seed, input int hold,
                             output int done_edge, output int bad);
        logic [7:0] q[$];
        logic [7:0] t;
        q = {};
        t = seed;
        for (int h = 0; h < hold; h++) q.push_back(seed);
        while (t != 8'd1 && q.size() < 1024) begin
            t = next_term(t);
            for (int h = 0; h < hold; h++) q.push_back(t);
        end
        done_edge = -1;
        bad = 0;
        for (int e = 0; e < q.size(); e++) begin
            data  = q[e];
            start = (e == 0);
            tick();
            if (done && done_edge < 0) done_edge = e;
            if (done_edge < 0 && !(busy && !done)) bad++;
            if (done_edge >= 0 && !(done && !busy)) bad++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data = 8'd6;
        tick();
        checks++;
        if (obs !== 21'd0) begin
            failures++;
            $display("FAIL reset_main got=%h exp=%h", obs, 21'd0);
        end
        checks++;
        if (obs_s !== 16'd0) begin
            failures++;
            $display("FAIL reset_small got=%h exp=%h", obs_s, 16'd0);
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_idle_ignores();
        for (int i = 0; i < 6; i++) begin
            data = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (obs !== 21'd0) begin
                failures++;
                $display("FAIL idle_ignores cycle=%0d got=%h exp=%h", i, obs, 21'd0);
            end
        end
    endtask

    task automatic test_directed();
        int de, bad, n, exp_s;
        logic [7:0] pk;
        bit ok;
        logic [7:0] seeds [4] = '{8'd6, 8'd6, 8'd5, 8'd27};
        int holds [4] = '{1, 3, 2, 1};
        for (int i = 0; i < 4; i++) begin
            model_run(seeds[i], n, pk, ok);
            if (!ok) continue;
            drive_run(seeds[i], holds[i], de, bad);
            checks++;
            if (de !== n * holds[i]) begin
                failures++;
                $display("FAIL directed_latency seed=%0d hold=%0d got=%0d exp=%0d", seeds[i], holds[i], de, n * holds[i]);
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL directed_busy_done seed=%0d got=%0d bad cycles exp=0", seeds[i], bad);
            end
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b0, (n > 255), 1'b0, 8'(n), pk}) begin
                failures++;
                $display("FAIL directed_result seed=%0d got=%h exp=%h", seeds[i], obs, {1'b0, 1'b1, 1'b0, (n > 255), 1'b0, 8'(n), pk});
            end
            exp_s = (n > 7) ? 7 : n;
            checks++;
            if ({done_s, steps_s, peak_s} !== {1'b1, 3'(exp_s), pk}) begin
                failures++;
                $display("FAIL small_result seed=%0d got=%h exp=%h", seeds[i], {done_s, steps_s, peak_s}, {1'b1, 3'(exp_s), pk});
            end
            if (n != 7) begin
                checks++;
                if (stepsat_s !== (n > 7)) begin
                    failures++;
                    $display("FAIL small_stepsat seed=%0d got=%b exp=%b", seeds[i], stepsat_s, (n > 7));
                end
            end
        end
    endtask

    task automatic test_seed_one();
        data = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1}) begin
            failures++;
            $display("FAIL seed_one got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1});
        end
    endtask

    task automatic test_seed_zero_stall();
        int first_done;
        first_done = -1;
        data = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done && first_done < 0) first_done = k;
        end
        checks++;
        if (first_done !== 16) begin
            failures++;
            $display("FAIL seed_zero_latency got=%0d exp=%0d", first_done, 16);
        end
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL seed_zero_result got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        end
    endtask

    task automatic test_stall_mid();
        data = 8'd6; start = 1'b1;
        tick();
        start = 1'b0; data = 8'd3;
        for (int k = 0; k < 16; k++) tick();
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL stall_mid_early got=%b exp=%b", {busy, done}, 2'b10);
        end
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd6}) begin
            failures++;
            $display("FAIL stall_mid_result got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd6});
        end
    endtask

    task automatic test_done_holds();
        int de, bad, n;
        logic [7:0] pk;
        bit ok;
        model_run(8'd6, n, pk, ok);
        drive_run(8'd6, 1, de, bad);
        for (int i = 0; i < 8; i++) begin
            data = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(n), pk}) begin
                failures++;
                $display("FAIL done_holds cycle=%0d got=%h exp=%h", i, obs, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(n), pk});
            end
        end
    endtask

    task automatic test_reset_mid_run();
        data = 8'd6; start = 1'b1;
        tick();
        start = 1'b0; data = 8'd3;
        tick();
        data = 8'd10;
        tick();
        rst = 1'b1; data = 8'd5;
        tick();
        rst = 1'b0;
        checks++;
        if ({obs, obs_s} !== 37'd0) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=%h", {obs, obs_s}, 37'd0);
        end
        data = 8'd16;
        tick();
        checks++;
        if (obs !== 21'd0) begin
            failures++;
            $display("FAIL reset_then_idle got=%h exp=%h", obs, 21'd0);
        end
    endtask

    task automatic test_back_to_back();
        int de, bad, n;
        logic [7:0] pk;
        bit ok;
        data = 8'd6; start = 1'b1;
        tick();
        start = 1'b0; data = 8'd3;
        tick();
        // restart mid-run with seed 5, then restart straight out of DONE with 7
        model_run(8'd5, n, pk, ok);
        drive_run(8'd5, 1, de, bad);
        checks++;
        if ({de, obs} !== {n, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(n), pk}) begin
            failures++;
            $display("FAIL restart_mid_run got=%0d/%h exp=%0d/%h", de, obs, n, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(n), pk});
        end
        model_run(8'd7, n, pk, ok);
        drive_run(8'd7, 2, de, bad);
        checks++;
        if ({de, bad, obs} !== {2 * n, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(n), pk}) begin
            failures++;
            $display("FAIL restart_from_done got=%0d/%0d/%h exp=%0d/0/%h", de, bad, obs, 2 * n, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(n), pk});
        end
    endtask

    task automatic test_random();
        int de, bad, n, hold, exp_s;
        logic [7:0] pk, seed;
        bit ok;
        for (int r = 0; r < 24; r++) begin
            ok = 1'b0;
            seed = 8'd1;
            n = 0;
            pk = 8'd1;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                seed = 8'($urandom_range(1, 255));
                model_run(seed, n, pk, ok);
            end
            if (!ok) begin
                seed = 8'd6;
                model_run(seed, n, pk, ok);
            end
            hold = $urandom_range(1, 4);
            drive_run(seed, hold, de, bad);
            checks++;
            if ({de, bad} !== {n * hold, 32'd0}) begin
                failures++;
                $display("FAIL random_timing seed=%0d hold=%0d got=%0d/%0d exp=%0d/0", seed, hold, de, bad, n * hold);
            end
            checks++;
            if (obs !== {1'b0, 1'b1, 1'b0, (n > 255), 1'b0, 8'(n), pk}) begin
                failures++;
                $display("FAIL random_result seed=%0d got=%h exp=%h", seed, obs, {1'b0, 1'b1, 1'b0, (n > 255), 1'b0, 8'(n), pk});
            end
            exp_s = (n > 7) ? 7 : n;
            checks++;
            if (steps_s !== 3'(exp_s)) begin
                failures++;
                $display("FAIL random_small_steps seed=%0d got=%0d exp=%0d", seed, steps_s, exp_s);
            end
        end
    endtask

    task automatic test_checker();
        data = 8'd6; start = 1'b1;
        tick();
        start = 1'b0; data = 8'd4;
        tick();
        checks++;
        if ({busy, cerr, steps} !== {1'b1, CE_ON, 8'd1}) begin
            failures++;
            $display("FAIL checker_flag got=%h exp=%h", {busy, cerr, steps}, {1'b1, CE_ON, 8'd1});
        end
        data = 8'd2;
        tick();
        data = 8'd1;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, CE_ON, 8'd3, 8'd6}) begin
            failures++;
            $display("FAIL checker_sticky got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 1'b0, CE_ON, 8'd3, 8'd6});
        end
        data = 8'd6; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, cerr} !== 2'b10) begin
            failures++;
            $display("FAIL checker_clear got=%b exp=%b", {busy, cerr}, 2'b10);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data = 8'd0;
        tick();
        test_reset();
        test_idle_ignores();
        test_directed();
        test_seed_one();
        test_seed_zero_stall();
        test_stall_mid();
        test_done_holds();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_checker();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
